n1_irq_sched: RTL and testbench
===============================

Name: n1_irq_sched

Overview:
Interrupt request scheduler for the N1 core. It sits between the 16 external level-sensitive IRQ lines and the flow controller (FC).
- Qualifies requests with a per-line mask and a global interrupt enable (GIE).
- Arbitrates among qualified requests by fixed priority or round-robin.
- Presents one vector at a time to the FC through a request/acknowledge handshake.
- Tracks the in-service interval until end-of-interrupt (EOI).

Parameters:
RR_EN, 0, 0 = fixed priority (line 0 highest); 1 = round-robin starting at the line after the last serviced one
EOI_GIE, 1, 1 = EOI sets GIE (RETI semantics); 0 = GIE is left cleared after EOI

Ports:
clk_i  in  1  module clock
sync_rst_i  in  1  synchronous reset, active-high
irq_req_i  in  16  level-sensitive interrupt requests
irq_mask_we_i  in  1  mask write strobe
irq_mask_dat_i  in  16  mask write data (1 = line enabled)
irq_mask_o  out  16  current mask register
irq_en_i  in  1  set GIE (pulse)
irq_dis_i  in  1  clear GIE (pulse)
fc_irq_o  out  1  interrupt request to FC
fc_irq_vec_o  out  4  vector of the presented/serviced line
fc_irq_ack_i  in  1  FC accepts the presented interrupt
fc_eoi_i  in  1  FC signals end of ISR
prb_state_o  out  2  FSM state (0 IDLE, 1 PEND, 2 SERV)
prb_gie_o  out  1  GIE value

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (sync_rst_i).
- Reset values, all regardless of state (reset during SERV or PEND aborts immediately):
  - irq_mask_o=0, GIE=0, state=IDLE
  - fc_irq_o=0, fc_irq_vec_o=0, round-robin pointer=0
- Eligibility: elig = irq_req_i & irq_mask_o & {16{GIE}}, using registered mask/GIE values.
- Mask write: irq_mask_we_i loads irq_mask_dat_i; the new mask takes effect on the next cycle.
- GIE update priority, highest first:
  1. irq_dis_i clears GIE (wins over irq_en_i and over EOI).
  2. Entry into SERV clears GIE.
  3. irq_en_i or (EOI with EOI_GIE=1) sets GIE.
- Winner selection:
  - RR_EN=0: lowest set index of elig.
  - RR_EN=1: first set bit scanning upward from the pointer, wrapping 15->0.
- FSM IDLE:
  - If elig!=0: register winner into fc_irq_vec_o, assert fc_irq_o, go to PEND.
  - Latency is exactly 1 cycle from elig going nonzero to fc_irq_o=1.
- FSM PEND:
  - fc_irq_o=1 and fc_irq_vec_o are held stable; no re-arbitration, even if a higher-priority line arrives.
  - If fc_irq_ack_i=1: go to SERV, deassert fc_irq_o, clear GIE, set pointer to (vec+1) mod 16.
  - Else if elig[vec]==0 (line dropped, masked, or GIE cleared): withdraw. Deassert fc_irq_o and go to IDLE next cycle; the pointer is unchanged.
  - An ack in the same cycle as a withdraw condition is honoured: the ack wins.
- FSM SERV:
  - fc_irq_o=0; fc_irq_vec_o keeps the serviced vector.
  - fc_eoi_i=1 -> IDLE, applying the EOI_GIE rule.
  - Arbitration can restart the cycle after EOI at the earliest, so fc_irq_o can rise 1 cycle after returning to IDLE.
- Ignored inputs:
  - fc_irq_ack_i outside PEND.
  - fc_eoi_i outside SERV.
- fc_irq_o is a registered output and never asserts while in SERV.
- A request line that is still active after its EOI is re-eligible. Under round-robin it loses to any other eligible line.

Test Plan:
1. Reset, mask=0xFFFF, irq_en, irq_req=0x0028 -> one cycle later fc_irq_o=1, vec=3. Ack -> fc_irq_o=0, state=SERV, GIE=0.
2. RR_EN=1: lines 2 and 5 held active; ack and EOI repeated four times -> vectors 2,5,2,5. With RR_EN=0 the same stimulus gives 2,2,2,2.
3. In PEND with vec=4, drop irq_req[4] -> next cycle fc_irq_o=0, state=IDLE. A same-cycle ack instead -> SERV with vec=4.
4. In PEND, write mask 0x0000 -> withdrawal. Then irq_en and irq_dis in the same cycle -> GIE=0.
5. EOI_GIE=1: EOI in SERV -> GIE=1, IDLE, re-request 1 cycle later if elig!=0. EOI together with irq_dis -> GIE=0, no re-request.
6. sync_rst_i asserted in SERV and again in PEND -> all outputs at their reset values next cycle. A stray ack/EOI in IDLE -> no state change.

Source files
------------

// File: rtl/n1_irq_sched.sv
// n1_irq_sched -- interrupt request scheduler for the N1 core.
//
// Qualifies 16 level-sensitive IRQ lines with a per-line mask and a global
// interrupt enable (GIE), picks one winner (fixed priority or round-robin),
// presents it to the flow controller (FC) via request/acknowledge, and
// tracks the in-service interval until end-of-interrupt (EOI).
//
// Parameters:
//   RR_EN   : 0 = fixed priority (line 0 highest), 1 = round-robin
//   EOI_GIE : 1 = EOI sets GIE (RETI semantics), 0 = GIE stays cleared
//
// Ports:
//   clk_i           in   module clock
//   sync_rst_i      in   synchronous reset, active-high
//   irq_req_i       in   [15:0] level-sensitive interrupt requests
//   irq_mask_we_i   in   mask write strobe
//   irq_mask_dat_i  in   [15:0] mask write data (1 = line enabled)
//   irq_mask_o      out  [15:0] current mask register
//   irq_en_i        in   set GIE (pulse)
//   irq_dis_i       in   clear GIE (pulse)
//   fc_irq_o        out  interrupt request to FC (registered)
//   fc_irq_vec_o    out  [3:0] vector of the presented/serviced line
//   fc_irq_ack_i    in   FC accepts the presented interrupt
//   fc_eoi_i        in   FC signals end of ISR
//   prb_state_o     out  [1:0] FSM state (0 IDLE, 1 PEND, 2 SERV)
//   prb_gie_o       out  GIE value

module n1_irq_sched #(
  parameter bit RR_EN   = 1'b0,
  parameter bit EOI_GIE = 1'b1
) (
  input  logic        clk_i,
  input  logic        sync_rst_i,
  input  logic [15:0] irq_req_i,
  input  logic        irq_mask_we_i,
  input  logic [15:0] irq_mask_dat_i,
  output logic [15:0] irq_mask_o,
  input  logic        irq_en_i,
  input  logic        irq_dis_i,
  output logic        fc_irq_o,
  output logic [3:0]  fc_irq_vec_o,
  input  logic        fc_irq_ack_i,
  input  logic        fc_eoi_i,
  output logic [1:0]  prb_state_o,
  output logic        prb_gie_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mask;
  logic        r_gie;
  logic        r_irq;
  logic [3:0]  r_vec;
  logic [3:0]  r_ptr;

  logic [15:0] w_elig;
  logic [3:0]  w_base;
  logic [3:0]  w_win;
  logic        w_any;
  logic        w_irq_nxt;
  logic [3:0]  w_vec_nxt;
  logic [3:0]  w_ptr_nxt;
  logic        w_gie_nxt;
  logic        w_enter_serv;
  logic        w_eoi_take;

  assign w_elig = irq_req_i & r_mask & {16{r_gie}};

  // Scan upward from the base index with 4-bit wraparound; fixed priority is
  // the same scan anchored at line 0.
  always_comb begin
    w_win  = '0;
    w_any  = 1'b0;
    w_base = RR_EN ? r_ptr : 4'd0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!w_any && w_elig[4'(w_base + 4'(i))]) begin
        w_win = 4'(w_base + 4'(i));
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_nxt    = r_irq;
    w_vec_nxt    = r_vec;
    w_ptr_nxt    = r_ptr;
    w_enter_serv = 1'b0;
    w_eoi_take   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_PEND;
          w_irq_nxt   = 1'b1;
          w_vec_nxt   = w_win;
        end
      end
      ST_PEND: begin
        // Ack takes precedence over a simultaneous withdraw condition.
        if (fc_irq_ack_i) begin
          w_state_nxt  = ST_SERV;
          w_irq_nxt    = 1'b0;
          w_enter_serv = 1'b1;
          w_ptr_nxt    = r_vec + 4'd1;
        end else if (!w_elig[r_vec]) begin
          w_state_nxt = ST_IDLE;
          w_irq_nxt   = 1'b0;
        end
      end
      ST_SERV: begin
        w_irq_nxt = 1'b0;
        if (fc_eoi_i) begin
          w_state_nxt = ST_IDLE;
          w_eoi_take  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_gie_nxt = r_gie;
    if (irq_dis_i)
      w_gie_nxt = 1'b0;
    else if (w_enter_serv)
      w_gie_nxt = 1'b0;
    else if (irq_en_i || (w_eoi_take && EOI_GIE))
      w_gie_nxt = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_gie   <= 1'b0;
      r_irq   <= 1'b0;
      r_vec   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gie   <= w_gie_nxt;
      r_irq   <= w_irq_nxt;
      r_vec   <= w_vec_nxt;
      r_ptr   <= w_ptr_nxt;
      if (irq_mask_we_i)
        r_mask <= irq_mask_dat_i;
    end
  end

  assign irq_mask_o   = r_mask;
  assign fc_irq_o     = r_irq;
  assign fc_irq_vec_o = r_vec;
  assign prb_state_o  = r_state;
  assign prb_gie_o    = r_gie;

endmodule

// File: tb/tb_n1_irq_sched.sv
// Directed testbench for n1_irq_sched. Three instances share one stimulus:
// u_dut (fixed priority, EOI sets GIE), u_rr (round-robin), u_ng (EOI leaves
// GIE cleared).

module tb_n1_irq_sched;

  logic        clk_i = 1'b0;
  logic        sync_rst_i;
  logic [15:0] irq_req_i;
  logic        irq_mask_we_i;
  logic [15:0] irq_mask_dat_i;
  logic        irq_en_i;
  logic        irq_dis_i;
  logic        fc_irq_ack_i;
  logic        fc_eoi_i;

  logic [15:0] d_mask, r_mask_o, n_mask;
  logic        d_irq, r_irq, n_irq;
  logic [3:0]  d_vec, r_vec, n_vec;
  logic [1:0]  d_st, r_st, n_st;
  logic        d_gie, r_gie, n_gie;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  n1_irq_sched #(.RR_EN(1'b0), .EOI_GIE(1'b1)) u_dut (
    .clk_i(clk_i), .sync_rst_i(sync_rst_i), .irq_req_i(irq_req_i),
    .irq_mask_we_i(irq_mask_we_i), .irq_mask_dat_i(irq_mask_dat_i),
    .irq_mask_o(d_mask), .irq_en_i(irq_en_i), .irq_dis_i(irq_dis_i),
    .fc_irq_o(d_irq), .fc_irq_vec_o(d_vec), .fc_irq_ack_i(fc_irq_ack_i),
    .fc_eoi_i(fc_eoi_i), .prb_state_o(d_st), .prb_gie_o(d_gie));

  n1_irq_sched #(.RR_EN(1'b1), .EOI_GIE(1'b1)) u_rr (
    .clk_i(clk_i), .sync_rst_i(sync_rst_i), .irq_req_i(irq_req_i),
    .irq_mask_we_i(irq_mask_we_i), .irq_mask_dat_i(irq_mask_dat_i),
    .irq_mask_o(r_mask_o), .irq_en_i(irq_en_i), .irq_dis_i(irq_dis_i),
    .fc_irq_o(r_irq), .fc_irq_vec_o(r_vec), .fc_irq_ack_i(fc_irq_ack_i),
    .fc_eoi_i(fc_eoi_i), .prb_state_o(r_st), .prb_gie_o(r_gie));

  n1_irq_sched #(.RR_EN(1'b0), .EOI_GIE(1'b0)) u_ng (
    .clk_i(clk_i), .sync_rst_i(sync_rst_i), .irq_req_i(irq_req_i),
    .irq_mask_we_i(irq_mask_we_i), .irq_mask_dat_i(irq_mask_dat_i),
    .irq_mask_o(n_mask), .irq_en_i(irq_en_i), .irq_dis_i(irq_dis_i),
    .fc_irq_o(n_irq), .fc_irq_vec_o(n_vec), .fc_irq_ack_i(fc_irq_ack_i),
    .fc_eoi_i(fc_eoi_i), .prb_state_o(n_st), .prb_gie_o(n_gie));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_clear();
    irq_mask_we_i = 1'b0;
    irq_en_i      = 1'b0;
    irq_dis_i     = 1'b0;
    fc_irq_ack_i  = 1'b0;
    fc_eoi_i      = 1'b0;
  endtask

  initial begin
    sync_rst_i     = 1'b1;
    irq_req_i      = '0;
    irq_mask_dat_i = '0;
    pulse_clear();
    step(); step();
    sync_rst_i = 1'b0;
    chk("rst_mask", 32'(d_mask), 32'h0);
    chk("rst_gie", 32'(d_gie), 32'h0);
    chk("rst_state", 32'(d_st), 32'h0);
    chk("rst_irq", 32'(d_irq), 32'h0);
    chk("rst_vec", 32'(d_vec), 32'h0);

    // 1: mask all, enable, request 3 and 5 -> vec 3 after one cycle
    irq_mask_we_i = 1'b1; irq_mask_dat_i = 16'hFFFF; irq_en_i = 1'b1;
    step(); pulse_clear();
    chk("t1_mask", 32'(d_mask), 32'hFFFF);
    chk("t1_gie", 32'(d_gie), 32'h1);
    irq_req_i = 16'h0028;
    step();
    chk("t1_irq", 32'(d_irq), 32'h1);
    chk("t1_vec", 32'(d_vec), 32'h3);
    chk("t1_state_pend", 32'(d_st), 32'h1);
    chk("t1_rr_vec", 32'(r_vec), 32'h3);
    fc_irq_ack_i = 1'b1;
    step(); pulse_clear();
    chk("t1_ack_irq", 32'(d_irq), 32'h0);
    chk("t1_ack_state", 32'(d_st), 32'h2);
    chk("t1_ack_gie", 32'(d_gie), 32'h0);
    chk("t1_serv_vec", 32'(d_vec), 32'h3);

    // 5a: EOI restores GIE (EOI_GIE=1) but not on u_ng; re-request 1 cycle later
    fc_eoi_i = 1'b1;
    step(); pulse_clear();
    chk("t5_eoi_state", 32'(d_st), 32'h0);
    chk("t5_eoi_gie", 32'(d_gie), 32'h1);
    chk("t5_eoi_irq", 32'(d_irq), 32'h0);
    chk("t5_ng_gie", 32'(n_gie), 32'h0);
    step();
    chk("t5_rereq_irq", 32'(d_irq), 32'h1);
    chk("t5_rereq_vec", 32'(d_vec), 32'h3);
    chk("t5_rr_vec5", 32'(r_vec), 32'h5);
    chk("t5_ng_irq", 32'(n_irq), 32'h0);

    // 4: mask write to 0 while pending -> withdraw one cycle after it lands
    irq_mask_we_i = 1'b1; irq_mask_dat_i = 16'h0000;
    step(); pulse_clear();
    chk("t4_still_pend", 32'(d_st), 32'h1);
    chk("t4_still_irq", 32'(d_irq), 32'h1);
    step();
    chk("t4_wd_state", 32'(d_st), 32'h0);
    chk("t4_wd_irq", 32'(d_irq), 32'h0);
    chk("t4_rr_wd_state", 32'(r_st), 32'h0);
    irq_en_i = 1'b1; irq_dis_i = 1'b1;
    step(); pulse_clear();
    chk("t4_en_dis_gie", 32'(d_gie), 32'h0);

    // 3: pending on line 4, drop the line -> withdraw
    irq_mask_we_i = 1'b1; irq_mask_dat_i = 16'hFFFF; irq_en_i = 1'b1;
    irq_req_i = 16'h0010;
    step(); pulse_clear();
    step();
    chk("t3_pend", 32'(d_st), 32'h1);
    chk("t3_vec", 32'(d_vec), 32'h4);
    irq_req_i = 16'h0000;
    step();
    chk("t3_drop_irq", 32'(d_irq), 32'h0);
    chk("t3_drop_state", 32'(d_st), 32'h0);
    irq_req_i = 16'h0010;
    step();
    chk("t3_pend2", 32'(d_st), 32'h1);
    // drop with simultaneous ack -> ack wins
    irq_req_i = 16'h0000; fc_irq_ack_i = 1'b1;
    step(); pulse_clear();
    chk("t3_ackwin_state", 32'(d_st), 32'h2);
    chk("t3_ackwin_vec", 32'(d_vec), 32'h4);
    chk("t3_ackwin_irq", 32'(d_irq), 32'h0);

    // 5b: EOI together with irq_dis -> GIE stays 0, no re-request
    irq_req_i = 16'h0010;
    fc_eoi_i = 1'b1; irq_dis_i = 1'b1;
    step(); pulse_clear();
    chk("t5_eoidis_state", 32'(d_st), 32'h0);
    chk("t5_eoidis_gie", 32'(d_gie), 32'h0);
    step();
    chk("t5_eoidis_noreq", 32'(d_irq), 32'h0);
    chk("t5_eoidis_idle", 32'(d_st), 32'h0);

    // 6: reset in SERV
    irq_en_i = 1'b1;
    step(); pulse_clear();
    step();
    chk("t6_pre_pend", 32'(d_st), 32'h1);
    fc_irq_ack_i = 1'b1;
    step(); pulse_clear();
    chk("t6_pre_serv", 32'(d_st), 32'h2);
    sync_rst_i = 1'b1;
    step();
    sync_rst_i = 1'b0;
    chk("t6_serv_rst_state", 32'(d_st), 32'h0);
    chk("t6_serv_rst_vec", 32'(d_vec), 32'h0);
    chk("t6_serv_rst_mask", 32'(d_mask), 32'h0);
    chk("t6_serv_rst_gie", 32'(d_gie), 32'h0);
    chk("t6_serv_rst_irq", 32'(d_irq), 32'h0);
    // reset in PEND
    irq_mask_we_i = 1'b1; irq_mask_dat_i = 16'hFFFF; irq_en_i = 1'b1;
    step(); pulse_clear();
    step();
    chk("t6_pre_pend2", 32'(d_st), 32'h1);
    sync_rst_i = 1'b1;
    step();
    sync_rst_i = 1'b0;
    chk("t6_pend_rst_irq", 32'(d_irq), 32'h0);
    chk("t6_pend_rst_state", 32'(d_st), 32'h0);
    chk("t6_pend_rst_vec", 32'(d_vec), 32'h0);
    chk("t6_pend_rst_mask", 32'(d_mask), 32'h0);
    // stray ack/EOI in IDLE
    fc_irq_ack_i = 1'b1; fc_eoi_i = 1'b1;
    step(); pulse_clear();
    chk("t6_stray_state", 32'(d_st), 32'h0);
    chk("t6_stray_gie", 32'(d_gie), 32'h0);

    // 2: lines 2 and 5 held; RR gives 2,5,2,5, fixed gives 2,2,2,2
    irq_req_i = 16'h0024;
    irq_mask_we_i = 1'b1; irq_mask_dat_i = 16'hFFFF; irq_en_i = 1'b1;
    step(); pulse_clear();
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_fix_vec%0d", k), 32'(d_vec), 32'h2);
      chk($sformatf("t2_rr_vec%0d", k), 32'(r_vec), (k % 2 == 0) ? 32'h2 : 32'h5);
      chk($sformatf("t2_rr_irq%0d", k), 32'(r_irq), 32'h1);
      fc_irq_ack_i = 1'b1;
      step(); pulse_clear();
      chk($sformatf("t2_rr_serv%0d", k), 32'(r_st), 32'h2);
      fc_eoi_i = 1'b1;
      step(); pulse_clear();
      chk($sformatf("t2_rr_gie%0d", k), 32'(r_gie), 32'h1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
